posit_align_ctrl: RTL
=====================

// Module: posit_align_ctrl
// PURPOSE
//  Multi-cycle operand-alignment controller in front of the posit adder. Accepts two unpacked
//  posit operands (valid/ready) and orders them with the existing comparator. Computes their
//  scale difference, then shifts the smaller mantissa right iteratively with sticky collection.
//  Presents big operand + aligned small mantissa to the add/normalise stage (valid/ready).
// PARAMETERS
//  W_REG      8   regime field width (signed)
//  W_EXP      3   exponent field width; values are always in [0, 2**ES)
//  ES         2   exponent bits per regime step; ES < W_EXP
//  W_MAN      12  mantissa width (unsigned, hidden bit included)
//  SHIFT_STEP 4   max right-shift bits per ALIGN cycle, 1..W_MAN
// PORTS
//  clk                 in   1      clock; all state on rising edge
//  rst_n               in   1      asynchronous, active-low reset
//  flush               in   1      sync abort: return to IDLE, drop any op in flight
//  in_valid / in_ready in/out 1    operand handshake; accept when both high
//  a_sign, b_sign      in   sign_t operand signs
//  a_regime, b_regime  in   W_REG  signed regimes
//  a_exponent, b_exp.  in   W_EXP  exponents
//  a_mantissa, b_man.  in   W_MAN  mantissas
//  out_valid/out_ready out/in 1    result handshake; transfer when both high
//  out_big_sign        out  sign_t sign of larger-magnitude operand
//  out_big_regime      out  W_REG  regime of larger operand
//  out_big_exponent    out  W_EXP  exponent of larger operand
//  out_big_mantissa    out  W_MAN  mantissa of larger operand
//  out_small_mantissa  out  W_MAN  smaller mantissa, right-shifted by out_shift
//  out_sticky          out  1      OR of all bits shifted out
//  out_eff_sub         out  1      big_sign XOR small_sign
//  out_shift           out  W_DIFF total scale difference (unsigned, W_DIFF = W_REG+ES+1)
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, every out_* register=0, rem=0; in_ready=1 once out of reset.
//  States: IDLE -> (accept) ALIGN or DONE; ALIGN -> ALIGN/DONE; DONE -> (out handshake) IDLE.
//  in_ready = (state==IDLE); combinational from state only, never from out_ready.
//  Accept edge: latch comparator big/small outputs, eff_sub, sticky=0.
//   diff = ((big_regime - small_regime) <<< ES) + (big_exp - small_exp), width W_DIFF, always >= 0.
//   out_shift=rem=diff; diff==0 -> DONE, else ALIGN.
//  ALIGN cycle: if rem >= W_MAN: sticky|=|man; man=0; rem=0 (single-cycle clamp).
//   else s=min(rem,SHIFT_STEP): sticky|=|(man & ((1<<s)-1)); man>>=s; rem-=s.
//   When rem reaches 0 -> DONE. ALIGN cycles = (diff>=W_MAN) ? 1 : ceil(diff/SHIFT_STEP).
//  DONE: out_valid=1; all out_* held stable until out_ready; on handshake -> IDLE, out_valid=0.
//  Latency accept -> out_valid: 1 + ALIGN cycles. No back-to-back accept in DONE (in_ready=0).
//  Equal magnitudes: comparator picks b as big; diff=0, sticky=0.
//  flush: highest priority; any state -> IDLE next edge, out_valid=0, no accept that cycle.
//  rst_n low mid-op: immediate return to reset values; operation lost, no partial output.
// STRUCTURE
//  common package gets: align_state_t enum {IDLE, ALIGN, DONE}; W_DIFF derivation function.
//  sign_t stays in common package. Sole sub-module: existing comparator, fed from in_* ports.
//  Everything else inline: FSM, rem counter, mantissa/sticky shift register, output registers.
// TESTING (W_REG=8, W_EXP=3, ES=2, W_MAN=12, SHIFT_STEP=4)
//  Operand equality: a=b={+,r=1,e=2,m=0x800} -> diff 0; out_valid 1 cycle after accept.
//   Response: small_man=0x800, sticky=0, eff_sub=0.
//  Shift with sticky: a={+,0,0,0xFFF}, b={-,1,2,0x800} -> big=b, shift=6, small_man=0x03F.
//   Response: sticky=1, eff_sub=1, 2 ALIGN cycles, out_valid 3 cycles after accept.
//  Clamp: a={+,-3,0,0x001}, b={+,2,0,0x900} -> shift=20 >= 12.
//   Response: small_man=0, sticky=1, out_valid 2 cycles after accept.
//  Backpressure: out_ready=0 for 5 cycles in DONE.
//   Response: out_* stable, in_ready=0, no new accept; handshake -> in_ready=1 next cycle.
//  Abort: flush pulse in 1st ALIGN cycle of test 2 -> IDLE next edge, out_valid never asserts.
//   rst_n low mid-ALIGN -> out_valid=0, out_* =0 asynchronously; in_ready=1 after release.
//  Exact multiple: a={+,0,1,0x8F0}, b={+,1,1,0xA00} -> shift=4.
//   Response: small_man=0x08F, sticky=0, 1 ALIGN cycle.

Source files
------------

// File: rtl/posit_align_ctrl_pkg.sv
// Shared types and helpers for the posit operand-alignment controller.
//   sign_t        : operand sign bit
//   align_state_t : controller states IDLE / ALIGN / DONE
//   w_diff()      : width of the scale-difference value (regime + exponent + sign headroom)
package posit_align_ctrl_pkg;

  typedef logic sign_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    DONE
  } align_state_t;

  function automatic int w_diff(input int w_reg, input int es);
    return w_reg + es + 1;
  endfunction

endpackage

// File: rtl/posit_align_ctrl_cmp.sv
// Magnitude comparator for two unpacked posit operands.
// Orders operands by (signed regime, exponent, mantissa). Equal magnitudes select b as big.
// Ports:
//   a_*, b_*          in   operand sign / regime / exponent / mantissa
//   big_*             out  fields of the larger-magnitude operand
//   small_*           out  fields of the smaller-magnitude operand (no small regime sign-only users)
module posit_align_ctrl_cmp
  import posit_align_ctrl_pkg::*;
#(
  parameter int W_REG = 8,
  parameter int W_EXP = 3,
  parameter int W_MAN = 12
) (
  input  sign_t            a_sign,
  input  logic [W_REG-1:0] a_regime,
  input  logic [W_EXP-1:0] a_exponent,
  input  logic [W_MAN-1:0] a_mantissa,
  input  sign_t            b_sign,
  input  logic [W_REG-1:0] b_regime,
  input  logic [W_EXP-1:0] b_exponent,
  input  logic [W_MAN-1:0] b_mantissa,
  output sign_t            big_sign,
  output logic [W_REG-1:0] big_regime,
  output logic [W_EXP-1:0] big_exponent,
  output logic [W_MAN-1:0] big_mantissa,
  output sign_t            small_sign,
  output logic [W_REG-1:0] small_regime,
  output logic [W_EXP-1:0] small_exponent,
  output logic [W_MAN-1:0] small_mantissa
);

  logic a_gt_b;

  always_comb begin
    a_gt_b = 1'b0;
    if ($signed(a_regime) != $signed(b_regime)) begin
      a_gt_b = $signed(a_regime) > $signed(b_regime);
    end else if (a_exponent != b_exponent) begin
      a_gt_b = a_exponent > b_exponent;
    end else begin
      a_gt_b = a_mantissa > b_mantissa;
    end
  end

  assign big_sign       = a_gt_b ? a_sign     : b_sign;
  assign big_regime     = a_gt_b ? a_regime   : b_regime;
  assign big_exponent   = a_gt_b ? a_exponent : b_exponent;
  assign big_mantissa   = a_gt_b ? a_mantissa : b_mantissa;
  assign small_sign     = a_gt_b ? b_sign     : a_sign;
  assign small_regime   = a_gt_b ? b_regime   : a_regime;
  assign small_exponent = a_gt_b ? b_exponent : a_exponent;
  assign small_mantissa = a_gt_b ? b_mantissa : a_mantissa;

endmodule

// File: rtl/posit_align_ctrl.sv
// Multi-cycle operand-alignment controller in front of the posit adder.
// Accepts two unpacked operands, orders them, computes the scale difference and shifts the
// smaller mantissa right by up to SHIFT_STEP bits per cycle while collecting a sticky bit.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort back to IDLE
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a_*, b_*              operand fields
//   out_valid / out_ready result handshake
//   out_big_*             larger operand fields
//   out_small_mantissa    aligned smaller mantissa
//   out_sticky            OR of all bits shifted out
//   out_eff_sub           effective subtraction flag
//   out_shift             total scale difference
module posit_align_ctrl
  import posit_align_ctrl_pkg::*;
#(
  parameter int W_REG      = 8,
  parameter int W_EXP      = 3,
  parameter int ES         = 2,
  parameter int W_MAN      = 12,
  parameter int SHIFT_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  sign_t                      a_sign,
  input  logic [W_REG-1:0]           a_regime,
  input  logic [W_EXP-1:0]           a_exponent,
  input  logic [W_MAN-1:0]           a_mantissa,
  input  sign_t                      b_sign,
  input  logic [W_REG-1:0]           b_regime,
  input  logic [W_EXP-1:0]           b_exponent,
  input  logic [W_MAN-1:0]           b_mantissa,
  output logic                       out_valid,
  input  logic                       out_ready,
  output sign_t                      out_big_sign,
  output logic [W_REG-1:0]           out_big_regime,
  output logic [W_EXP-1:0]           out_big_exponent,
  output logic [W_MAN-1:0]           out_big_mantissa,
  output logic [W_MAN-1:0]           out_small_mantissa,
  output logic                       out_sticky,
  output logic                       out_eff_sub,
  output logic [w_diff(W_REG,ES)-1:0] out_shift
);

  localparam int W_DIFF = w_diff(W_REG, ES);
  localparam logic [W_DIFF-1:0] MAN_LIM  = W_DIFF'(W_MAN);
  localparam logic [W_DIFF-1:0] STEP_LIM = W_DIFF'(SHIFT_STEP);

  align_state_t state;
  logic [W_DIFF-1:0] rem;

  sign_t            big_sign, small_sign;
  logic [W_REG-1:0] big_regime, small_regime;
  logic [W_EXP-1:0] big_exponent, small_exponent;
  logic [W_MAN-1:0] big_mantissa, small_mantissa;

  posit_align_ctrl_cmp #(
    .W_REG (W_REG),
    .W_EXP (W_EXP),
    .W_MAN (W_MAN)
  ) u_cmp (
    .a_sign         (a_sign),
    .a_regime       (a_regime),
    .a_exponent     (a_exponent),
    .a_mantissa     (a_mantissa),
    .b_sign         (b_sign),
    .b_regime       (b_regime),
    .b_exponent     (b_exponent),
    .b_mantissa     (b_mantissa),
    .big_sign       (big_sign),
    .big_regime     (big_regime),
    .big_exponent   (big_exponent),
    .big_mantissa   (big_mantissa),
    .small_sign     (small_sign),
    .small_regime   (small_regime),
    .small_exponent (small_exponent),
    .small_mantissa (small_mantissa)
  );

  // Scale difference in modular W_DIFF arithmetic; the true value is non-negative and fits.
  logic [W_DIFF-1:0] big_r_ext, small_r_ext, big_e_ext, small_e_ext, diff;
  assign big_r_ext   = {{(W_DIFF-W_REG){big_regime[W_REG-1]}}, big_regime};
  assign small_r_ext = {{(W_DIFF-W_REG){small_regime[W_REG-1]}}, small_regime};
  assign big_e_ext   = {{(W_DIFF-W_EXP){1'b0}}, big_exponent};
  assign small_e_ext = {{(W_DIFF-W_EXP){1'b0}}, small_exponent};
  assign diff        = ((big_r_ext - small_r_ext) << ES) + (big_e_ext - small_e_ext);

  // One alignment step: shift by min(rem, SHIFT_STEP), or clear outright once rem >= W_MAN.
  logic              at_clamp;
  logic [W_DIFF-1:0] step;
  logic [W_DIFF-1:0] rem_next;
  logic [W_MAN-1:0]  mask;
  logic [W_MAN-1:0]  shifted;
  logic              lost;

  always_comb begin
    at_clamp = rem >= MAN_LIM;
    step     = (rem < STEP_LIM) ? rem : STEP_LIM;
    mask     = ~({W_MAN{1'b1}} << step);
    shifted  = out_small_mantissa >> step;
    lost     = |(out_small_mantissa & mask);
    rem_next = rem - step;
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      rem                <= '0;
      out_valid          <= 1'b0;
      out_big_sign       <= 1'b0;
      out_big_regime     <= '0;
      out_big_exponent   <= '0;
      out_big_mantissa   <= '0;
      out_small_mantissa <= '0;
      out_sticky         <= 1'b0;
      out_eff_sub        <= 1'b0;
      out_shift          <= '0;
    end else if (flush) begin
      state     <= IDLE;
      rem       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_big_sign       <= big_sign;
            out_big_regime     <= big_regime;
            out_big_exponent   <= big_exponent;
            out_big_mantissa   <= big_mantissa;
            out_small_mantissa <= small_mantissa;
            out_sticky         <= 1'b0;
            out_eff_sub        <= big_sign ^ small_sign;
            out_shift          <= diff;
            rem                <= diff;
            if (diff == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          // out_valid rises on the edge that completes the last step.
          if (at_clamp) begin
            out_sticky         <= out_sticky | (|out_small_mantissa);
            out_small_mantissa <= '0;
            rem                <= '0;
            state              <= DONE;
            out_valid          <= 1'b1;
          end else begin
            out_sticky         <= out_sticky | lost;
            out_small_mantissa <= shifted;
            rem                <= rem_next;
            if (rem_next == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
